// File: rtl/lfsr_checker.sv
// Receive-side checker for the x^8+x^4+x^3+x^2+1 Fibonacci LFSR word stream.
// Seeds from the received data, then flywheels its prediction and counts bad words.
module lfsr_checker #(
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned LOSS_COUNT = 3
) (
   input  logic        clock,
   input  logic        rst,
   input  logic [7:0]  data_in,
   input  logic        data_valid,
   input  logic        clear_count,
   output logic        locked,
   output logic        err_strobe,
   output logic [15:0] err_count,
   output logic [7:0]  expected,
   output logic [1:0]  state_dbg
);

   // data_valid qualifies data_in for exactly one word per high cycle; there is
   // no back-pressure, and with data_valid low every piece of state holds.

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);
   localparam logic [3:0] LOSS_RUN = 4'(LOSS_COUNT);

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return {x[6:0], x[1] ^ x[2] ^ x[3] ^ x[7]};
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  pred_q, pred_d;
   logic [3:0]  run_q, run_d;
   logic [15:0] err_count_q, err_count_d;
   logic        err_strobe_q, err_strobe_d;
   logic [3:0]  run_inc;
   logic        word_match;
   logic        word_zero;

   assign run_inc    = run_q + 4'd1;
   assign word_match = (data_in == pred_q);
   assign word_zero  = (data_in == 8'h00);

   always_comb begin
      state_d      = state_q;
      pred_d       = pred_q;
      run_d        = run_q;
      err_count_d  = err_count_q;
      err_strobe_d = 1'b0;

      if (data_valid) begin
         unique case (state_q)
            HUNT: begin
               if (!word_zero) begin
                  pred_d  = lfsr_next(data_in);
                  run_d   = 4'd0;
                  state_d = VERIFY;
               end
            end

            VERIFY: begin
               if (word_match) begin
                  pred_d = lfsr_next(data_in);
                  if (run_inc == LOCK_RUN) begin
                     state_d = LOCKED;
                     run_d   = 4'd0;
                  end else begin
                     run_d = run_inc;
                  end
               end else if (!word_zero) begin
                  pred_d = lfsr_next(data_in);
                  run_d  = 4'd0;
               end else begin
                  state_d = HUNT;
                  run_d   = 4'd0;
               end
            end

            LOCKED: begin
               // Flywheel: the prediction advances from itself, never from data_in.
               pred_d = lfsr_next(pred_q);
               if (word_match) begin
                  run_d = 4'd0;
               end else begin
                  err_strobe_d = 1'b1;
                  if (err_count_q != 16'hFFFF) begin
                     err_count_d = err_count_q + 16'd1;
                  end
                  if (run_inc == LOSS_RUN) begin
                     state_d = HUNT;
                     run_d   = 4'd0;
                  end else begin
                     run_d = run_inc;
                  end
               end
            end

            default: begin
               state_d = HUNT;
               run_d   = 4'd0;
            end
         endcase
      end

      if (clear_count) begin
         err_count_d = 16'h0000;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q      <= HUNT;
         pred_q       <= 8'h00;
         run_q        <= 4'd0;
         err_count_q  <= 16'h0000;
         err_strobe_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pred_q       <= pred_d;
         run_q        <= run_d;
         err_count_q  <= err_count_d;
         err_strobe_q <= err_strobe_d;
      end
   end

   assign locked     = (state_q == LOCKED);
   assign err_strobe = err_strobe_q;
   assign err_count  = err_count_q;
   assign expected   = pred_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: acquisition, flywheel, loss, reseed, saturation, reset.
module tb_lfsr_checker;

   logic        clock;
   logic        rst;
   logic [7:0]  data_in;
   logic        data_valid;
   logic        clear_count;
   logic        locked;
   logic        err_strobe;
   logic [15:0] err_count;
   logic [7:0]  expected;
   logic [1:0]  state_dbg;

   logic        s_rst;
   logic [7:0]  s_data_in;
   logic        s_data_valid;
   logic        s_clear_count;
   logic        s_locked;
   logic        s_err_strobe;
   logic [15:0] s_err_count;
   logic [7:0]  s_expected;
   logic [1:0]  s_state_dbg;

   int unsigned n_checks;
   int unsigned n_errors;

   logic [7:0]  sat_pred;
   int unsigned sat_run;

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;

   lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
      .clock       (clock),
      .rst         (rst),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .clear_count (clear_count),
      .locked      (locked),
      .err_strobe  (err_strobe),
      .err_count   (err_count),
      .expected    (expected),
      .state_dbg   (state_dbg)
   );

   // Long loss window so the counter can be driven to saturation without dropping lock.
   lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15)) dut_sat (
      .clock       (clock),
      .rst         (s_rst),
      .data_in     (s_data_in),
      .data_valid  (s_data_valid),
      .clear_count (s_clear_count),
      .locked      (s_locked),
      .err_strobe  (s_err_strobe),
      .err_count   (s_err_count),
      .expected    (s_expected),
      .state_dbg   (s_state_dbg)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return {x[6:0], x[1] ^ x[2] ^ x[3] ^ x[7]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks: inputs change 1 time unit after the edge, outputs read there too
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      data_valid = 1'b0;
      clear_count = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      data_in = d;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      data_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic sat_send(input logic [7:0] d);
      s_data_in = d;
      s_data_valid = 1'b1;
      tick();
      s_data_valid = 1'b0;
   endtask

   task automatic sat_err();
      if (sat_run == 14) begin
         sat_send(sat_pred);
         sat_pred = lfsr_next(sat_pred);
         sat_run = 0;
      end
      sat_send(~sat_pred);
      sat_pred = lfsr_next(sat_pred);
      sat_run++;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      data_in = 8'h00;
      data_valid = 1'b0;
      clear_count = 1'b0;
      rst = 1'b1;
      s_rst = 1'b1;
      s_data_in = 8'h00;
      s_data_valid = 1'b0;
      s_clear_count = 1'b0;

      // reset state
      do_reset();
      s_rst = 1'b0;
      check_eq("rst_locked", 32'(locked), 32'h0);
      check_eq("rst_strobe", 32'(err_strobe), 32'h0);
      check_eq("rst_count", 32'(err_count), 32'h0);
      check_eq("rst_expected", 32'(expected), 32'h00);
      check_eq("rst_state", 32'(state_dbg), 32'(ST_HUNT));

      // acquisition from 0x01
      send(8'h01);
      check_eq("seed_state", 32'(state_dbg), 32'(ST_VERIFY));
      check_eq("seed_expected", 32'(expected), 32'h02);
      send(8'h02);
      send(8'h05);
      send(8'h0B);
      check_eq("acq_not_yet", 32'(locked), 32'h0);
      send(8'h16);
      check_eq("acq_locked", 32'(locked), 32'h1);
      check_eq("acq_expected", 32'(expected), 32'h2C);
      check_eq("acq_count", 32'(err_count), 32'h0);

      // single bad word, flywheel keeps prediction
      send(8'h00);
      check_eq("err1_strobe", 32'(err_strobe), 32'h1);
      check_eq("err1_count", 32'(err_count), 32'h1);
      check_eq("err1_locked", 32'(locked), 32'h1);
      check_eq("err1_expected", 32'(expected), 32'h58);
      send(8'h58);
      check_eq("fly1_strobe", 32'(err_strobe), 32'h0);
      send(8'hB1);
      check_eq("fly2_strobe", 32'(err_strobe), 32'h0);
      check_eq("fly2_count", 32'(err_count), 32'h1);
      check_eq("fly2_expected", 32'(expected), 32'h63);

      // loss of lock after three consecutive bad words
      send(8'hFF);
      send(8'hFF);
      check_eq("loss2_locked", 32'(locked), 32'h1);
      check_eq("loss2_count", 32'(err_count), 32'h3);
      send(8'hFF);
      check_eq("loss3_locked", 32'(locked), 32'h0);
      check_eq("loss3_count", 32'(err_count), 32'h4);
      check_eq("loss3_strobe", 32'(err_strobe), 32'h1);
      check_eq("loss3_expected", 32'(expected), 32'h1E);
      send(8'h00);
      send(8'h00);
      check_eq("hunt_zero_state", 32'(state_dbg), 32'(ST_HUNT));
      check_eq("hunt_zero_strobe", 32'(err_strobe), 32'h0);
      check_eq("hunt_zero_count", 32'(err_count), 32'h4);

      // reseed inside VERIFY
      send(8'h01);
      send(8'h02);
      send(8'h77);
      check_eq("reseed_state", 32'(state_dbg), 32'(ST_VERIFY));
      check_eq("reseed_expected", 32'(expected), 32'hEE);
      send(8'hEE);
      send(8'hDC);
      send(8'hB9);
      check_eq("reseed_not_yet", 32'(locked), 32'h0);
      send(8'h72);
      check_eq("reseed_locked", 32'(locked), 32'h1);
      check_eq("reseed_expected2", 32'(expected), 32'hE5);
      check_eq("reseed_count", 32'(err_count), 32'h4);

      // clear_count with no word
      clear_count = 1'b1;
      tick();
      clear_count = 1'b0;
      check_eq("clear_count", 32'(err_count), 32'h0);
      check_eq("clear_locked", 32'(locked), 32'h1);

      // acquisition with data_valid gaps
      do_reset();
      send(8'h01);
      idle(2);
      check_eq("gap_expected", 32'(expected), 32'h02);
      check_eq("gap_state", 32'(state_dbg), 32'(ST_VERIFY));
      send(8'h02);
      idle(1);
      send(8'h05);
      idle(3);
      send(8'h0B);
      idle(1);
      check_eq("gap_not_yet", 32'(locked), 32'h0);
      send(8'h16);
      check_eq("gap_locked", 32'(locked), 32'h1);
      check_eq("gap_expected2", 32'(expected), 32'h2C);
      send(8'h00);
      check_eq("gap_err_count", 32'(err_count), 32'h1);
      idle(1);
      check_eq("gap_strobe_drop", 32'(err_strobe), 32'h0);
      check_eq("gap_expected3", 32'(expected), 32'h58);

      // reset while locked
      rst = 1'b1;
      data_in = 8'h58;
      data_valid = 1'b1;
      tick();
      rst = 1'b0;
      data_valid = 1'b0;
      check_eq("mid_rst_locked", 32'(locked), 32'h0);
      check_eq("mid_rst_count", 32'(err_count), 32'h0);
      check_eq("mid_rst_expected", 32'(expected), 32'h00);
      check_eq("mid_rst_strobe", 32'(err_strobe), 32'h0);

      // saturation on the long-loss instance
      sat_send(8'h01);
      sat_send(8'h02);
      sat_send(8'h05);
      sat_send(8'h0B);
      sat_send(8'h16);
      check_eq("sat_locked", 32'(s_locked), 32'h1);
      sat_pred = 8'h2C;
      sat_run = 0;
      for (int i = 0; i < 65534; i++) sat_err();
      check_eq("sat_fffe", 32'(s_err_count), 32'hFFFE);
      sat_err();
      check_eq("sat_ffff", 32'(s_err_count), 32'hFFFF);
      sat_err();
      check_eq("sat_hold", 32'(s_err_count), 32'hFFFF);
      check_eq("sat_strobe", 32'(s_err_strobe), 32'h1);
      check_eq("sat_still_locked", 32'(s_locked), 32'h1);
      s_clear_count = 1'b1;
      sat_err();
      s_clear_count = 1'b0;
      check_eq("clr_err_count", 32'(s_err_count), 32'h0);
      check_eq("clr_err_strobe", 32'(s_err_strobe), 32'h1);
      tick();
      check_eq("clr_idle_strobe", 32'(s_err_strobe), 32'h0);

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 8-bit Fibonacci LFSR pattern generator (polynomial x^8+x^4+x^3+x^2+1, next = {q[6:0], q[1]^q[2]^q[3]^q[7]}). Samples the generator's 8-bit word stream, self-synchronises by seeding from the received data, then flywheels its own prediction and counts mismatching words. Sits at the far end of a link or datapath under test and reports lock status and an error count for bit-error measurement.

## Interface
- LOCK_COUNT, 4: consecutive matching words required, after seeding, to declare lock (1..15).
- LOSS_COUNT, 3: consecutive mismatching words, while locked, that force loss of lock (1..15).
- clock  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  received LFSR word.
- data_valid  input  1  data_in is a new word this cycle; when low, all state holds.
- clear_count  input  1  synchronous clear of err_count.
- locked  output  1  checker is in LOCKED.
- err_strobe  output  1  one-cycle pulse per mismatching word while LOCKED.
- err_count  output  16  saturating count of mismatching words while LOCKED.
- expected  output  8  current prediction for the next valid word.

## Operation
- Function next(x) = {x[6:0], x[1]^x[2]^x[3]^x[7]}. 0x00 is the lock-up state and is never a valid seed.
- States: HUNT, VERIFY, LOCKED. Internal: pred[7:0] (drives expected), run counter [3:0].
- HUNT: valid word d != 0x00 -> pred = next(d), run = 0, go VERIFY. d == 0x00 -> stay HUNT.
- VERIFY, valid word d:
  - d == pred -> run+1, pred = next(d); if run+1 == LOCK_COUNT -> go LOCKED, run = 0.
  - d != pred, d != 0x00 -> reseed: pred = next(d), run = 0, stay VERIFY.
  - d != pred, d == 0x00 -> go HUNT.
  - No errors counted in VERIFY.
- LOCKED, valid word d: pred = next(pred) always (flywheel; received errors never corrupt the prediction).
  - d == pred -> run = 0.
  - d != pred -> err_strobe, err_count +1 (saturate at 0xFFFF), run+1; if run+1 == LOSS_COUNT -> go HUNT, run = 0.
- data_valid low: no state, pred, run or count change; err_strobe low.
- clear_count: err_count = 0 next cycle; clear wins over a simultaneous increment (result 0), err_strobe still pulses.
- Reset values: state HUNT, pred 0x00, run 0, locked 0, err_strobe 0, err_count 0x0000, expected 0x00.

## Timing
- All outputs registered; locked and expected decoded from registered state/pred.
- Word sampled at edge N -> err_strobe high for cycle N+1 only; err_count updated at N+1.
- locked rises the cycle after the LOCK_COUNT-th matching word is sampled; falls the cycle after the LOSS_COUNT-th consecutive bad word.
- Minimum acquisition from HUNT: 1 + LOCK_COUNT valid words.
- rst asserted mid-operation overrides all inputs that edge; returns to HUNT with reset values next cycle.
- Back-to-back valid words (data_valid held high) supported at one word per clock, no bubbles.

## Test plan
- Reset then stream 0x01,0x02,0x05,0x0B,0x16 (valid each cycle), LOCK_COUNT=4 -> locked rises one cycle after 0x16 sampled, expected = 0x2C, err_count 0.
- Locked, send 0x00 in place of 0x2C, then 0x58,0xB1 -> single err_strobe pulse, err_count = 1, locked stays 1, 0x58 and 0xB1 match (flywheel).
- Locked, LOSS_COUNT=3, send three consecutive 0xFF -> err_count +3, locked falls the cycle after the third; then 0x00 words keep state in HUNT.
- VERIFY with 0x01,0x02,0x77 then 0x77's true successors -> reseed at 0x77, lock after 4 further matches, err_count unchanged.
- err_count preset near 0xFFFF via errors, more errors -> holds 0xFFFF; clear_count coincident with an error -> err_count 0, err_strobe 1.
- data_valid toggled low between words of 0x01..0x16 -> same lock result; rst pulsed while locked -> locked 0, err_count 0, expected 0x00 next cycle.
